qs_enq: RTL and testbench
=========================

// Module: qs_enq
// PURPOSE
//  Ingress front-end of the qs sorter: accepts an unsorted packet stream and
//  writes it word-by-word into the current memory bank. On EOP it hands the
//  bank to the sort engine via the scoreboard (BANK_IDLE->LOADING->READY).
//  Producer end of the bank-state protocol whose consumer is qs_deq.
//  Banks are visited round-robin in the same order as the dequeue side.
// PARAMETERS
//  W      qs_pkg::W   data word width
//  N      qs_pkg::N   bank depth in words (power of 2)
//  BANKS  qs_pkg::BANKS  number of banks
// PORTS
//  clk           in   1        clock (single clock domain)
//  rst           in   1        asynchronous reset, active-high
//  in_vld        in   1        input word valid
//  in_sop        in   1        first word of packet
//  in_eop        in   1        last word of packet
//  in_dat        in   W        input word
//  in_rdy_r      out  1        block can accept a word; transfer = in_vld & in_rdy_r
//  bank_idx_r    out  bank_id_t  bank currently owned by enqueue
//  bank_in       in   bank_state_t  scoreboard state of bank_idx_r
//  bank_out_vld  out  1        write-back strobe for bank_idx_r (combinational)
//  bank_out      out  bank_state_t  new scoreboard state
//  wr_en_r       out  1        memory write enable
//  wr_addr_r     out  addr_t   memory write address
//  wr_data_r     out  w_t      memory write data
// BEHAVIOUR
//  Reset: fsm=IDLE, in_rdy_r=0, wr_en_r=0, bank_idx_r=0, wr_addr_r=0,
//   bank_out_vld=0 (comb). Reset mid-packet abandons the packet; scoreboard
//   reset is owned elsewhere.
//  FSM: IDLE -> WAIT_SOP -> LOAD -> IDLE.
//   IDLE: when bank_in.status==BANK_IDLE: bank_out_vld=1, status=LOADING,
//    wr_addr<=0, in_rdy_r<=1, go WAIT_SOP. Otherwise wait (backpressure).
//   WAIT_SOP: transfer with !in_sop is dropped (no write). Transfer with
//    in_sop writes at addr 0 and goes LOAD. sop&eop together (1-word packet)
//    completes as in LOAD/EOP below.
//   LOAD: each transfer writes; wr_addr increments after each write.
//    A sop seen in LOAD restarts the packet: written at addr 0, err cleared.
//    EOP transfer: bank_out_vld=1, status=BANK_READY, n=addr of final word
//    (count-1), err=overflow flag; in_rdy_r<=0, bank_idx_r<=bank_id_inc,
//    go IDLE.
//  Overflow: transfers beyond N words are not written; err flag set; n
//   saturates at N-1; stays in LOAD until EOP.
//  Latency: accepted word appears on wr_en_r/wr_addr_r/wr_data_r exactly
//   1 cycle after transfer. in_rdy_r is registered; deasserts the cycle after
//   the EOP transfer, so no word follows EOP into the same bank.
//  bank_out_vld is asserted in LOAD every cycle (status LOADING, n=current
//   addr) so the scoreboard tracks fill level; EOP overrides.
//  Width: wr_addr is addr_t (clog2 N); increments never wrap (saturate).
// STRUCTURE
//  qs_pkg: W, N, BANKS, addr_t, w_t, bank_id_t, bank_id_inc(),
//   bank_status_t {IDLE,LOADING,READY,SORTED,UNLOADING}, bank_state_t
//   {status, n, err}. err field is new; qs_deq consumes it for out_err_r.
//  Single module; FSM and write pipeline in one file, no sub-module.
// TESTING
//  4-word pkt {1,2,3,4} into idle bank0 -> writes addr0..3 at T+1..T+4;
//   bank0 READY, n=3, err=0; bank_idx_r=1.
//  1-word pkt (sop&eop, dat=0xA5) -> one write addr0; READY, n=0.
//  N+2-word pkt -> N writes only; READY, n=N-1, err=1.
//  bank1 status SORTED while in IDLE -> in_rdy_r stays 0, no writes,
//   until status becomes IDLE; then LOADING written next cycle.
//  Word without sop then sop-packet {7,8} -> stray word dropped; addr0=7,
//   addr1=8, n=1.
//  rst asserted after 2 words -> next cycle all outputs at reset values;
//   new packet loads bank0 from addr0.

Source files
------------

// File: rtl/qs_pkg.sv
// Shared types and geometry for the qs sorter: word/address/bank types,
// the bank-state scoreboard record, and the round-robin bank step.
package qs_pkg;

  localparam int W     = 16;
  localparam int N     = 8;
  localparam int BANKS = 4;
  localparam int AW    = $clog2(N);
  localparam int BW    = $clog2(BANKS);

  typedef logic [W-1:0]  w_t;
  typedef logic [AW-1:0] addr_t;
  typedef logic [BW-1:0] bank_id_t;

  typedef enum logic [2:0] {
    BANK_IDLE,
    BANK_LOADING,
    BANK_READY,
    BANK_SORTED,
    BANK_UNLOADING
  } bank_status_t;

  typedef struct packed {
    bank_status_t status;
    addr_t        n;
    logic         err;
  } bank_state_t;

  typedef enum logic [1:0] {
    ENQ_IDLE,
    ENQ_WAIT_SOP,
    ENQ_LOAD
  } enq_state_t;

  function automatic bank_id_t bank_id_inc(input bank_id_t b);
    return (b == bank_id_t'(BANKS - 1)) ? '0 : bank_id_t'(b + 1'b1);
  endfunction

endpackage

// File: rtl/qs_enq.sv
// Ingress front-end of the qs sorter: claims an idle bank, writes one packet
// into it word by word and hands it to the sort engine as READY on EOP.
module qs_enq
  import qs_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_vld,
  input  logic        in_sop,
  input  logic        in_eop,
  input  w_t          in_dat,
  output logic        in_rdy_r,
  output bank_id_t    bank_idx_r,
  input  bank_state_t bank_in,
  output logic        bank_out_vld,
  output bank_state_t bank_out,
  output logic        wr_en_r,
  output addr_t       wr_addr_r,
  output w_t          wr_data_r
);

  localparam addr_t ADDR_MAX = addr_t'(N - 1);

  enq_state_t state;
  addr_t      ptr;    // address of the next word to write; saturates at N-1
  logic       full;   // address N-1 already written, further words overflow
  logic       err_r;
  logic       xfer;
  logic       pkt_end;

  assign xfer    = in_vld & in_rdy_r;
  // An EOP only closes a packet that has started (or starts on this word).
  assign pkt_end = xfer & in_eop & (in_sop | (state == ENQ_LOAD));

  // NOTE: every output of this block is given a default first so no latch is inferred.
  always_comb begin
    bank_out_vld = 1'b0;
    bank_out     = '{status: BANK_LOADING, n: ptr, err: err_r};
    if (!rst) begin
      case (state)
        ENQ_IDLE: begin
          if (bank_in.status == BANK_IDLE) begin
            bank_out_vld = 1'b1;
            bank_out     = '{status: BANK_LOADING, n: '0, err: 1'b0};
          end
        end
        ENQ_WAIT_SOP: begin
          if (pkt_end) begin
            bank_out_vld = 1'b1;
            bank_out     = '{status: BANK_READY, n: '0, err: 1'b0};
          end
        end
        ENQ_LOAD: begin
          bank_out_vld = 1'b1;
          if (pkt_end) begin
            bank_out.status = BANK_READY;
            bank_out.n      = in_sop ? '0 : ptr;
            bank_out.err    = in_sop ? 1'b0 : (err_r | full);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ENQ_IDLE;
      in_rdy_r   <= 1'b0;
      bank_idx_r <= '0;
      ptr        <= '0;
      full       <= 1'b0;
      err_r      <= 1'b0;
      wr_en_r    <= 1'b0;
      wr_addr_r  <= '0;
      wr_data_r  <= '0;
    end else begin
      // NOTE: non-blocking assignments only; the default below makes wr_en_r a one-cycle strobe.
      wr_en_r <= 1'b0;
      case (state)
        ENQ_IDLE: begin
          if (bank_in.status == BANK_IDLE) begin
            ptr       <= '0;
            full      <= 1'b0;
            err_r     <= 1'b0;
            wr_addr_r <= '0;
            in_rdy_r  <= 1'b1;
            state     <= ENQ_WAIT_SOP;
          end
        end
        ENQ_WAIT_SOP, ENQ_LOAD: begin
          if (xfer) begin
            if (in_sop) begin
              // SOP always (re)starts the packet at address 0.
              wr_en_r   <= 1'b1;
              wr_addr_r <= '0;
              wr_data_r <= in_dat;
              ptr       <= addr_t'(1);
              full      <= 1'b0;
              err_r     <= 1'b0;
            end else if (state == ENQ_LOAD) begin
              if (!full) begin
                wr_en_r   <= 1'b1;
                wr_addr_r <= ptr;
                wr_data_r <= in_dat;
                if (ptr == ADDR_MAX) full <= 1'b1;
                else                 ptr  <= ptr + 1'b1;
              end else begin
                err_r <= 1'b1;
              end
            end
            if (pkt_end) begin
              in_rdy_r   <= 1'b0;
              bank_idx_r <= bank_id_inc(bank_idx_r);
              state      <= ENQ_IDLE;
            end else if (in_sop) begin
              state <= ENQ_LOAD;
            end
          end
        end
        default: state <= ENQ_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_qs_enq.sv
// Self-checking bench for qs_enq: directed scenarios plus random packets,
// checked against a packet-level reference model and a bench-owned scoreboard.
module tb_qs_enq;
  import qs_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_vld = 1'b0;
  logic        in_sop = 1'b0;
  logic        in_eop = 1'b0;
  w_t          in_dat = '0;
  logic        in_rdy_r;
  bank_id_t    bank_idx_r;
  bank_state_t bank_in;
  logic        bank_out_vld;
  bank_state_t bank_out;
  logic        wr_en_r;
  addr_t       wr_addr_r;
  w_t          wr_data_r;

  qs_enq dut (
    .clk          (clk),
    .rst          (rst),
    .in_vld       (in_vld),
    .in_sop       (in_sop),
    .in_eop       (in_eop),
    .in_dat       (in_dat),
    .in_rdy_r     (in_rdy_r),
    .bank_idx_r   (bank_idx_r),
    .bank_in      (bank_in),
    .bank_out_vld (bank_out_vld),
    .bank_out     (bank_out),
    .wr_en_r      (wr_en_r),
    .wr_addr_r    (wr_addr_r),
    .wr_data_r    (wr_data_r)
  );

  always #5 clk = ~clk;

  // Scoreboard owned by the bench; its reset is external to the DUT.
  bank_state_t sb [BANKS];
  logic        set_req = 1'b0;
  bank_id_t    set_idx = '0;
  bank_state_t set_val = '0;

  assign bank_in = sb[bank_idx_r];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < BANKS; b++) sb[b] <= '{status: BANK_IDLE, n: '0, err: 1'b0};
    end else begin
      if (bank_out_vld) sb[bank_idx_r] <= bank_out;
      if (set_req)      sb[set_idx]    <= set_val;
    end
  end

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state: packet-level view of the stream.
  bit       m_in_pkt = 1'b0;
  int       m_cnt    = 0;
  bit       m_err    = 1'b0;
  bank_id_t m_bank   = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sb_set(input bank_id_t idx, input bank_status_t st);
    @(negedge clk);
    set_req = 1'b1;
    set_idx = idx;
    set_val = '{status: st, n: '0, err: 1'b0};
    @(posedge clk);
    #1 set_req = 1'b0;
  endtask

  // Waits (bounded) for ready, transfers one word, and checks the write and
  // scoreboard effects one cycle later against the reference model.
  task automatic send(input logic sop, input logic eop, input w_t dat, input int gap);
    bit          got;
    bit          exp_wr;
    int          exp_addr;
    bit          exp_end;
    bank_id_t    eb;
    bank_state_t exp_st;
    got      = 1'b0;
    exp_wr   = 1'b0;
    exp_addr = 0;
    exp_end  = 1'b0;
    eb       = m_bank;
    exp_st   = '0;
    repeat (gap) @(negedge clk);
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (in_rdy_r === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    check("rdy_wait", 64'(got), 64'(1));
    if (!got) return;
    in_vld = 1'b1;
    in_sop = sop;
    in_eop = eop;
    in_dat = dat;
    if (sop) begin
      m_in_pkt = 1'b1;
      m_cnt    = 0;
      m_err    = 1'b0;
    end
    if (m_in_pkt) begin
      if (m_cnt < N) begin
        exp_wr   = 1'b1;
        exp_addr = m_cnt;
        m_cnt++;
      end else begin
        m_err = 1'b1;
      end
      if (eop) begin
        exp_end  = 1'b1;
        exp_st   = '{status: BANK_READY, n: addr_t'(m_cnt - 1), err: m_err};
        m_in_pkt = 1'b0;
        m_bank   = bank_id_t'((int'(m_bank) + 1) % BANKS);
      end
    end
    @(posedge clk);
    #1;
    in_vld = 1'b0;
    in_sop = 1'b0;
    in_eop = 1'b0;
    check("wr_en", 64'(wr_en_r), 64'(exp_wr));
    if (exp_wr) begin
      check("wr_addr", 64'(wr_addr_r), 64'(exp_addr));
      check("wr_data", 64'(wr_data_r), 64'(dat));
    end
    if (exp_end) begin
      check("eop_state", 64'(sb[eb]), 64'(exp_st));
      check("bank_idx", 64'(bank_idx_r), 64'(m_bank));
    end else if (m_in_pkt) begin
      check("loading", 64'(sb[m_bank].status), 64'(BANK_LOADING));
    end
  endtask

  initial begin
    int       len;
    bank_id_t pb;
    logic     s;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_rdy", 64'(in_rdy_r), 64'(0));
    check("rst_wr_en", 64'(wr_en_r), 64'(0));
    check("rst_bank_idx", 64'(bank_idx_r), 64'(0));
    check("rst_wr_addr", 64'(wr_addr_r), 64'(0));
    check("rst_bank_vld", 64'(bank_out_vld), 64'(0));
    rst = 1'b0;
    sb_set(bank_id_t'(1), BANK_SORTED);

    // 4-word packet into bank 0
    send(1'b1, 1'b0, w_t'(1), 0);
    send(1'b0, 1'b0, w_t'(2), 0);
    send(1'b0, 1'b0, w_t'(3), 0);
    send(1'b0, 1'b1, w_t'(4), 0);

    // Bank 1 is SORTED: enqueue must stall until it returns to IDLE
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      check("stall_rdy", 64'(in_rdy_r), 64'(0));
      check("stall_wr", 64'(wr_en_r), 64'(0));
    end
    sb_set(bank_id_t'(1), BANK_IDLE);
    check("claim_vld", 64'(bank_out_vld), 64'(1));
    check("claim_status", 64'(bank_out.status), 64'(BANK_LOADING));
    @(posedge clk);
    #1;
    check("claim_rdy", 64'(in_rdy_r), 64'(1));
    check("claim_sb", 64'(sb[1].status), 64'(BANK_LOADING));

    // 1-word packet into bank 1
    send(1'b1, 1'b1, w_t'(16'h00A5), 0);

    // Overflow packet of N+2 words into bank 2
    for (int i = 0; i < N + 2; i++) send(i == 0, i == N + 1, w_t'($urandom), 0);

    // Stray word, then {7,8} into bank 3
    send(1'b0, 1'b0, w_t'(16'h0055), 0);
    send(1'b1, 1'b0, w_t'(7), 0);
    send(1'b0, 1'b1, w_t'(8), 0);

    // Reset in the middle of a packet in bank 0
    sb_set(bank_id_t'(0), BANK_IDLE);
    send(1'b1, 1'b0, w_t'(16'h0101), 0);
    send(1'b0, 1'b0, w_t'(16'h0202), 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_rdy", 64'(in_rdy_r), 64'(0));
    check("mid_rst_wr_en", 64'(wr_en_r), 64'(0));
    check("mid_rst_bank_idx", 64'(bank_idx_r), 64'(0));
    check("mid_rst_wr_addr", 64'(wr_addr_r), 64'(0));
    check("mid_rst_bank_vld", 64'(bank_out_vld), 64'(0));
    m_in_pkt = 1'b0;
    m_cnt    = 0;
    m_err    = 1'b0;
    m_bank   = '0;
    @(negedge clk);
    rst = 1'b0;
    send(1'b1, 1'b0, w_t'(16'h0303), 0);
    send(1'b0, 1'b1, w_t'(16'h0404), 0);
    sb_set(bank_id_t'(0), BANK_IDLE);

    // Random packets: stray words, mid-packet restarts, overflow, gaps
    for (int p = 0; p < 10; p++) begin
      if ($urandom_range(3) == 0) send(1'b0, 1'($urandom_range(1)), w_t'($urandom), 0);
      pb  = m_bank;
      len = $urandom_range(N + 3, 1);
      for (int i = 0; i < len; i++) begin
        s = (i == 0) || ($urandom_range(7) == 0);
        send(s, i == len - 1, w_t'($urandom), $urandom_range(2));
      end
      sb_set(pb, BANK_IDLE);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
